logic_unit_pipe: RTL

Parametrised, pipelined successor to the single-cycle logic unit in the ALU.
- Computes one of eight bitwise operations on two WIDTH-bit operands.
- Carries results through a STAGES-deep pipeline with a valid/ready handshake and global stall.
- Adds result flags (zero, parity) and a chain mode that substitutes the last accepted result for operand A.
- Sits beside the arithmetic/shift/compare units under the ALU top and is driven by the register-file/control FSM.

---
 rtl/logic_unit_pkg.sv | 29 ++
 rtl/logic_pipe_stage.sv | 40 ++++
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared definitions for the pipelined logic unit.
//   - 3-bit opcode encodings (LU_AND .. LU_PASSB)
//   - bit positions of the zero/parity flags inside a stage's flag field
//   - pack_flags(): builds that flag field from the individual flags
package logic_unit_pkg;

  localparam logic [2:0] LU_AND   = 3'b000;
  localparam logic [2:0] LU_OR    = 3'b001;
  localparam logic [2:0] LU_NAND  = 3'b010;
  localparam logic [2:0] LU_NOR   = 3'b011;
  localparam logic [2:0] LU_XOR   = 3'b100;
  localparam logic [2:0] LU_XNOR  = 3'b101;
  localparam logic [2:0] LU_NOT   = 3'b110;
  localparam logic [2:0] LU_PASSB = 3'b111;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_W      = 2;

  // Place the zero and parity flags at their fixed positions.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic zero, input logic parity);
    logic [FLAG_W-1:0] f;
    f              = {FLAG_W{1'b0}};
    f[FLAG_ZERO]   = zero;
    f[FLAG_PARITY] = parity;
    return f;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one register slice of the logic-unit pipeline.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   stall           hold every register when 1
//   in_valid/data/flags    slice input
//   out_valid/data/flags   registered slice output
// Data and flags load only with a valid entry, so a bubble leaves the last
// result in place (logic_out holds while logic_flag=0).
import logic_unit_pkg::*;

module logic_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [FLAG_W-1:0] out_flags
);

  // Slice register: reset, hold on stall, otherwise shift forward.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_flags <= {FLAG_W{1'b0}};
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= in_data;
        out_flags <= in_flags;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with valid/ready handshake.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   logic_enable   request valid (accepted when logic_enable && logic_ready)
//   alu_fun        opcode (see logic_unit_pkg)
//   chain          1 = operand A replaced by the accumulator
//   A, B           operands
//   out_ready      downstream can take a result this cycle
//   logic_ready    unit can accept a request this cycle
//   logic_flag     logic_out valid
//   logic_out      result
//   zero_flag      logic_out == 0, qualified by logic_flag
//   parity_flag    XOR-reduce of logic_out
// The result and flags are computed at the input and registered into stage
// 1; the remaining stages only delay them.
import logic_unit_pkg::*;

module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             logic_enable,
  input  logic [2:0]       alu_fun,
  input  logic             chain,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             out_ready,
  output logic             logic_ready,
  output logic             logic_flag,
  output logic [WIDTH-1:0] logic_out,
  output logic             zero_flag,
  output logic             parity_flag
);

  logic [WIDTH-1:0]  acc_r;
  logic [WIDTH-1:0]  op_a_s;
  logic [WIDTH-1:0]  result_s;
  logic              stall_s;
  logic              accept_s;

  // Index 0 is the pipeline input, index STAGES the output slice.
  logic              valid_s [0:STAGES];
  logic [WIDTH-1:0]  data_s  [0:STAGES];
  logic [FLAG_W-1:0] flags_s [0:STAGES];

  // Stall only when the last slice holds an untaken result.
  assign stall_s     = valid_s[STAGES] && !out_ready;
  assign logic_ready = !stall_s;
  assign accept_s    = logic_enable && logic_ready;

  assign op_a_s = chain ? acc_r : A;

  // Opcode decode.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (alu_fun)
      LU_AND:   result_s = op_a_s & B;
      LU_OR:    result_s = op_a_s | B;
      LU_NAND:  result_s = ~(op_a_s & B);
      LU_NOR:   result_s = ~(op_a_s | B);
      LU_XOR:   result_s = op_a_s ^ B;
      LU_XNOR:  result_s = ~(op_a_s ^ B);
      LU_NOT:   result_s = ~op_a_s;
      LU_PASSB: result_s = B;
      default:  result_s = {WIDTH{1'b0}};
    endcase
  end

  assign valid_s[0] = logic_enable;
  assign data_s[0]  = result_s;
  assign flags_s[0] = pack_flags(~|result_s, ^result_s);

  // Accumulator tracks the last accepted result; frozen during stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      acc_r <= result_s;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .stall     (stall_s),
      .in_valid  (valid_s[i]),
      .in_data   (data_s[i]),
      .in_flags  (flags_s[i]),
      .out_valid (valid_s[i+1]),
      .out_data  (data_s[i+1]),
      .out_flags (flags_s[i+1])
    );
  end

  assign logic_flag  = valid_s[STAGES];
  assign logic_out   = data_s[STAGES];
  assign zero_flag   = flags_s[STAGES][FLAG_ZERO] & valid_s[STAGES];
  assign parity_flag = flags_s[STAGES][FLAG_PARITY];

endmodule
